// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: fetches the instruction at the current PC over req/ack,
// holds it for the decoder over valid/ready, and computes the PC register's next value.
module instruction_fetch_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned WAIT_LIMIT  = 15
) (
  input  logic                   input_Clock,
  input  logic                   input_Reset,
  input  logic [PC_WIDTH-1:0]    input_PC,
  output logic [PC_WIDTH-1:0]    output_Next_PC,
  output logic                   output_Mem_Req,
  output logic [PC_WIDTH-1:0]    output_Mem_Addr,
  input  logic                   input_Mem_Ack,
  input  logic [INSTR_WIDTH-1:0] input_Mem_Data,
  output logic [INSTR_WIDTH-1:0] output_Instr,
  output logic                   output_Instr_Valid,
  input  logic                   input_Instr_Ready,
  input  logic                   input_Branch_Taken,
  input  logic [PC_WIDTH-1:0]    input_Branch_Target,
  output logic                   output_Fetch_Error
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  // Count value on which the next missing ack is the WAIT_LIMIT-th one.
  localparam logic [7:0] WaitLast = 8'(WAIT_LIMIT - 1);

  state_e                 state_q;
  logic [7:0]             wait_cnt_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   error_q;

  always_ff @(posedge input_Clock or posedge input_Reset) begin
    if (input_Reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      instr_q    <= '0;
      error_q    <= 1'b0;
    end else if (input_Branch_Taken) begin
      // Redirect wins over any same-cycle ack or ready.
      state_q    <= StReq;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StReq;
        end
        StReq: begin
          if (input_Mem_Ack) begin
            instr_q    <= input_Mem_Data;
            wait_cnt_q <= '0;
            state_q    <= StHold;
          end else if (wait_cnt_q == WaitLast) begin
            // Timeout: flag it and keep retrying the same address.
            error_q    <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StHold: begin
          if (input_Instr_Ready) begin
            state_q <= StReq;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The PC register always loads, so "hold" means feeding the current PC back.
  always_comb begin
    output_Next_PC = input_PC;
    if (input_Branch_Taken) begin
      output_Next_PC = input_Branch_Target;
    end else if (state_q == StHold && input_Instr_Ready) begin
      output_Next_PC = input_PC + PC_WIDTH'(1);
    end
  end

  assign output_Mem_Req     = (state_q == StReq);
  assign output_Mem_Addr    = input_PC;
  assign output_Instr       = instr_q;
  assign output_Instr_Valid = (state_q == StHold);
  assign output_Fetch_Error = error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: models the PC register around the DUT, applies a
// table of per-cycle vectors, then hand-written timeout and mid-fetch reset sequences.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  pc;
  logic [7:0]  next_pc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(
    .PC_WIDTH   (8),
    .INSTR_WIDTH(16),
    .WAIT_LIMIT (15)
  ) dut (
    .input_Clock        (clk),
    .input_Reset        (rst),
    .input_PC           (pc),
    .output_Next_PC     (next_pc),
    .output_Mem_Req     (mem_req),
    .output_Mem_Addr    (mem_addr),
    .input_Mem_Ack      (mem_ack),
    .input_Mem_Data     (mem_data),
    .output_Instr       (instr),
    .output_Instr_Valid (instr_valid),
    .input_Instr_Ready  (instr_ready),
    .input_Branch_Taken (br_taken),
    .input_Branch_Target(br_target),
    .output_Fetch_Error (fetch_err)
  );

  // PC register with no enable, reset to 0 alongside the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 8'h00;
    else     pc <= next_pc;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ack;
    logic        ready;
    logic        br;
    logic [7:0]  tgt;
    logic [15:0] data;
    logic        req;
    logic        valid;
    logic [7:0]  addr;
    logic [7:0]  npc;
    logic [15:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              ack ready br tgt    data      req valid addr   npc    instr     err
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h1000, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h1000, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h1000, 1'b0, 1'b1, 8'h00, 8'h01, 16'h1000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h1001, 1'b1, 1'b0, 8'h01, 8'h01, 16'h1000, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h1001, 1'b0, 1'b1, 8'h01, 8'h02, 16'h1001, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h1002, 1'b1, 1'b0, 8'h02, 8'h02, 16'h1001, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h1002, 1'b0, 1'b1, 8'h02, 8'h03, 16'h1002, 1'b0};
    // Ack delayed three cycles, then arrives with 0xABCD.
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h1003, 1'b1, 1'b0, 8'h03, 8'h03, 16'h1002, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h1003, 1'b1, 1'b0, 8'h03, 8'h03, 16'h1002, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h1003, 1'b1, 1'b0, 8'h03, 8'h03, 16'h1002, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 16'hABCD, 1'b1, 1'b0, 8'h03, 8'h03, 16'h1002, 1'b0};
    // Decoder stalls five cycles; stray ack data must not disturb the held word.
    for (int i = 11; i <= 15; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h1234, 1'b0, 1'b1, 8'h03, 8'h03, 16'hABCD, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h03, 8'h04, 16'hABCD, 1'b0};
    // Branch coincides with ack: data dropped, refetch at 0x40.
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h40, 16'h1004, 1'b1, 1'b0, 8'h04, 8'h40, 16'hABCD, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h1040, 1'b1, 1'b0, 8'h40, 8'h40, 16'hABCD, 1'b0};
    // Branch with ready in hold: target wins over PC+1.
    vecs[19] = '{1'b0, 1'b1, 1'b1, 8'h40, 16'h0000, 1'b0, 1'b1, 8'h40, 8'h40, 16'h1040, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h2040, 1'b1, 1'b0, 8'h40, 8'h40, 16'h1040, 1'b0};
    // Jump to 0xFF and check wrap to 0x00.
    vecs[21] = '{1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000, 1'b0, 1'b1, 8'h40, 8'hFF, 16'h2040, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h10FF, 1'b1, 1'b0, 8'hFF, 8'hFF, 16'h2040, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'hFF, 8'h00, 16'h10FF, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 16'h10FF, 1'b0};

    rst         = 1'b1;
    mem_ack     = 1'b1;
    mem_data    = 16'h1000;
    instr_ready = 1'b1;
    br_taken    = 1'b0;
    br_target   = 8'h00;

    // No request or valid while reset is held, even with ack/ready asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", i, 32'(mem_req), 32'd0);
      chk("rst_valid", i, 32'(instr_valid), 32'd0);
    end
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      mem_ack     = vecs[i].ack;
      instr_ready = vecs[i].ready;
      br_taken    = vecs[i].br;
      br_target   = vecs[i].tgt;
      mem_data    = vecs[i].data;
      @(negedge clk);
      chk("req", i, 32'(mem_req), 32'(vecs[i].req));
      chk("valid", i, 32'(instr_valid), 32'(vecs[i].valid));
      chk("addr", i, 32'(mem_addr), 32'(vecs[i].addr));
      chk("next_pc", i, 32'(next_pc), 32'(vecs[i].npc));
      chk("instr", i, 32'(instr), 32'(vecs[i].instr));
      chk("err", i, 32'(fetch_err), 32'(vecs[i].err));
      next_cycle();
    end

    // Timeout: fresh reset, then no ack for WAIT_LIMIT request cycles.
    rst         = 1'b1;
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("to_req", i, 32'(mem_req), 32'd1);
      chk("to_hold_pc", i, 32'(next_pc), 32'd0);
      chk("to_err_low", i, 32'(fetch_err), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_err_high", 0, 32'(fetch_err), 32'd1);
    chk("to_retry_req", 0, 32'(mem_req), 32'd1);
    for (int i = 0; i < 16; i++) next_cycle();
    mem_ack  = 1'b1;
    mem_data = 16'h5555;
    next_cycle();
    @(negedge clk);
    chk("to_fetch_valid", 0, 32'(instr_valid), 32'd1);
    chk("to_fetch_instr", 0, 32'(instr), 32'h5555);
    chk("to_err_sticky", 0, 32'(fetch_err), 32'd1);

    // Mid-fetch asynchronous reset with an ack pending.
    mem_ack     = 1'b0;
    instr_ready = 1'b1;
    next_cycle();
    mem_ack  = 1'b1;
    mem_data = 16'h7777;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req", 0, 32'(mem_req), 32'd0);
    chk("ar_valid", 0, 32'(instr_valid), 32'd0);
    chk("ar_err", 0, 32'(fetch_err), 32'd0);
    chk("ar_instr", 0, 32'(instr), 32'd0);
    next_cycle();
    rst         = 1'b0;
    instr_ready = 1'b0;
    mem_data    = 16'h1000;
    @(negedge clk);
    chk("ar_idle_req", 0, 32'(mem_req), 32'd0);
    chk("ar_idle_instr", 0, 32'(instr), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("ar_fetch_req", 0, 32'(mem_req), 32'd1);
    chk("ar_fetch_addr", 0, 32'(mem_addr), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("ar_fetch_valid", 0, 32'(instr_valid), 32'd1);
    chk("ar_fetch_instr", 0, 32'(instr), 32'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
